// File: rtl/c1541_track_cache.sv
// c1541_track_cache: buffers one D64 track in local RAM between the SD host and the GCR stage.
// A head-track change loads the whole track as consecutive 512-byte SD blocks.
// A save request writes the cached track back to SD before any new load starts.
module c1541_track_cache #(
  parameter int MAX_TRACK = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        change,
  input  logic [5:0]  track,
  input  logic        save_track,
  input  logic [4:0]  sector,
  input  logic [7:0]  buff_addr,
  output logic [7:0]  buff_dout,
  input  logic [7:0]  buff_din,
  input  logic        buff_we,
  output logic        busy,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  input  logic        sd_buff_wr
);
  localparam logic [6:0] MAXT = 7'(MAX_TRACK);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;
  state_t state, state_nx;

  logic [5:0]  cur_track;
  logic        save_pend, load_pend, change_d;
  logic [3:0]  blk, blk_nx, blk_inc;
  logic        load_take, save_done;

  logic [10:0] tt, off;
  logic [4:0]  nsect, nblk_raw;
  logic [3:0]  nblk;
  logic        half;
  logic [9:0]  first_lba;
  logic [31:0] lba;

  logic        change_rise, trk_ok, new_ok, save_req, abort;
  logic [12:0] sd_addr, drv_addr;
  logic        drv_ok, drv_we, sd_we;

  logic [7:0]  ram [0:6143];

  // Zone geometry of the cached track: sector offset in the image and sectors per track.
  always_comb begin
    tt = {5'd0, cur_track};
    if (cur_track < 6'd17) begin
      off = 11'd21 * tt;
      nsect = 5'd21;
    end else if (cur_track < 6'd24) begin
      off = 11'd357 + 11'd19 * (tt - 11'd17);
      nsect = 5'd19;
    end else if (cur_track < 6'd30) begin
      off = 11'd490 + 11'd18 * (tt - 11'd24);
      nsect = 5'd18;
    end else begin
      off = 11'd598 + 11'd17 * (tt - 11'd30);
      nsect = 5'd17;
    end
    half      = off[0];
    first_lba = off[10:1];
    nblk_raw  = ({4'd0, half} + nsect + 5'd1) >> 1;
    nblk      = (nblk_raw > 5'd11) ? 4'd11 : nblk_raw[3:0];
  end

  assign change_rise = change & ~change_d;
  assign trk_ok      = {1'b0, cur_track} < MAXT;
  assign new_ok      = {1'b0, track} < MAXT;
  // A save pulse in the same cycle as a disk change targets the old image and is dropped.
  assign save_req    = (save_pend | save_track) & ~change_rise;
  assign abort       = load_pend | change_rise;
  assign blk_inc     = blk + 4'd1;
  assign lba         = {22'd0, first_lba} + {28'd0, blk};

  assign busy = (state != IDLE) | save_pend | load_pend | ((track != cur_track) & new_ok);

  // Next-state, block counter and SD request outputs.
  always_comb begin
    state_nx  = state;
    blk_nx    = blk;
    load_take = 1'b0;
    save_done = 1'b0;
    sd_rd     = 1'b0;
    sd_wr     = 1'b0;
    sd_lba    = 32'd0;
    case (state)
      IDLE: begin
        if (save_req && trk_ok) begin
          state_nx = WR_REQ;
          blk_nx   = 4'd0;
        end else begin
          // nothing to write back for an unbacked track; drop any stale request
          save_done = 1'b1;
          if ((track != cur_track) || load_pend) begin
            load_take = 1'b1;
            if (new_ok) begin
              state_nx = RD_REQ;
              blk_nx   = 4'd0;
            end
          end
        end
      end
      WR_REQ: begin
        sd_wr  = 1'b1;
        sd_lba = lba;
        if (sd_ack) state_nx = WR_WAIT;
      end
      WR_WAIT: begin
        sd_lba = lba;
        if (!sd_ack) begin
          blk_nx = blk_inc;
          if (blk_inc == nblk) begin
            save_done = 1'b1;
            state_nx  = IDLE;
          end else if (abort) state_nx = IDLE;
          else state_nx = WR_REQ;
        end
      end
      RD_REQ: begin
        sd_rd  = 1'b1;
        sd_lba = lba;
        if (sd_ack) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        sd_lba = lba;
        if (!sd_ack) begin
          blk_nx = blk_inc;
          if ((blk_inc == nblk) || abort) state_nx = IDLE;
          else state_nx = RD_REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, track tag and pending-request flags; a disk change wins over save requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_track <= 6'h3F;
      save_pend <= 1'b0;
      load_pend <= 1'b0;
      blk       <= 4'd0;
      change_d  <= 1'b0;
    end else begin
      state    <= state_nx;
      blk      <= blk_nx;
      change_d <= change;
      if (load_take) cur_track <= track;
      if (change_rise)     save_pend <= 1'b0;
      else if (save_track) save_pend <= 1'b1;
      else if (save_done)  save_pend <= 1'b0;
      if (change_rise)     load_pend <= 1'b1;
      else if (load_take)  load_pend <= 1'b0;
    end
  end

  assign sd_addr  = {blk, sd_buff_addr};
  assign drv_addr = {sector + {4'd0, half}, buff_addr};
  assign drv_ok   = (sector < nsect) & trk_ok;
  assign drv_we   = buff_we & drv_ok & ~busy;
  assign sd_we    = sd_buff_wr & (state == RD_WAIT);

  // Track RAM; SD fills only happen while busy, so the two writers never collide.
  always_ff @(posedge clk) begin
    if (sd_we)       ram[sd_addr]  <= sd_buff_dout;
    else if (drv_we) ram[drv_addr] <= buff_din;
  end

  // Registered read ports; out-of-range drive reads return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      buff_dout   <= 8'h00;
      sd_buff_din <= 8'h00;
    end else begin
      buff_dout   <= drv_ok ? ram[drv_addr] : 8'h00;
      sd_buff_din <= ram[sd_addr];
    end
  end
endmodule
